branch_predictor: RTL and testbench

//  Fetch-side partner of the execute-stage branch comparator. Predicts each fetched branch

---
 rtl/branch_predictor.sv | 138 +++++++++++++
 tb/tb_branch_predictor.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped 2-bit counters plus a tagged BTB, trained by
// resolved branches from EX, with a registered redirect on mispredict. Optional stats: BRANCH_PRED_STATS_EN.
module branch_predictor #(
  parameter int WORD_WIDTH  = 32,
  parameter int INDEX_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] pc_f,
  output logic                  pred_taken_f,
  output logic [WORD_WIDTH-1:0] pred_target_f,
  input  logic                  res_valid,
  input  logic [WORD_WIDTH-1:0] res_pc,
  input  logic                  res_taken,
  input  logic [WORD_WIDTH-1:0] res_target,
  input  logic                  res_pred_taken,
  input  logic [WORD_WIDTH-1:0] res_pred_target,
  output logic                  redirect_valid,
  output logic [WORD_WIDTH-1:0] redirect_pc
`ifdef BRANCH_PRED_STATS_EN
  ,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
`endif
);

  localparam int ENTRIES   = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = WORD_WIDTH - INDEX_WIDTH - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // One table row holds the counter FSM state alongside its BTB fields.
  typedef struct packed {
    ctr_t                  ctr;
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [WORD_WIDTH-1:0] target;
  } entry_t;

  entry_t                  table_q [ENTRIES];
  entry_t                  f_entry;
  ctr_t                    r_ctr;
  ctr_t                    ctr_next;
  logic [INDEX_WIDTH-1:0]  f_idx;
  logic [INDEX_WIDTH-1:0]  r_idx;
  logic [TAG_WIDTH-1:0]    f_tag;
  logic [TAG_WIDTH-1:0]    r_tag;
  logic                    mispredict;
  logic [WORD_WIDTH-1:0]   correct_pc;
  logic                    unused_pc_bits;

  assign f_idx          = pc_f[INDEX_WIDTH+1:2];
  assign f_tag          = pc_f[WORD_WIDTH-1:INDEX_WIDTH+2];
  assign r_idx          = res_pc[INDEX_WIDTH+1:2];
  assign r_tag          = res_pc[WORD_WIDTH-1:INDEX_WIDTH+2];
  assign unused_pc_bits = ^pc_f[1:0];

  assign f_entry = table_q[f_idx];
  assign r_ctr   = table_q[r_idx].ctr;

  // State register: counters and BTB; writes land at the edge, so same-cycle reads see old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{ctr: WNT, valid: 1'b0, tag: '0, target: '0};
      end
    end else if (res_valid) begin
      table_q[r_idx].ctr <= ctr_next;
      if (res_taken) begin
        table_q[r_idx].valid  <= 1'b1;
        table_q[r_idx].tag    <= r_tag;
        table_q[r_idx].target <= res_target;
      end
    end
  end

  // Next-state: saturating walk SNT <-> WNT <-> WT <-> ST for the resolved entry.
  always_comb begin
    ctr_next = r_ctr;
    case (r_ctr)
      SNT:     ctr_next = res_taken ? WNT : SNT;
      WNT:     ctr_next = res_taken ? WT  : SNT;
      WT:      ctr_next = res_taken ? ST  : WNT;
      ST:      ctr_next = res_taken ? ST  : WT;
      default: ctr_next = WNT;
    endcase
  end

  // Output: prediction for the fetch PC; target is exposed whenever the entry is valid.
  always_comb begin
    pred_taken_f  = 1'b0;
    pred_target_f = '0;
    if (f_entry.valid) begin
      pred_target_f = f_entry.target;
      pred_taken_f  = (f_entry.tag == f_tag) && ((f_entry.ctr == WT) || (f_entry.ctr == ST));
    end
  end

  assign mispredict = res_valid &
                      ((res_taken != res_pred_taken) |
                       (res_taken & res_pred_taken & (res_target != res_pred_target)));
  assign correct_pc = res_taken ? res_target : (res_pc + WORD_WIDTH'(4));

  // redirect_pc keeps its last value between mispredicts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) begin
        redirect_pc <= correct_pc;
      end
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (res_valid && (stat_branches != 32'hFFFF_FFFF)) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, hand sequences, and randomized traffic
// against an array-based reference model with a redirect scoreboard.
module tb_branch_predictor;

  localparam int NENT = 64;

  logic        clk;
  logic        reset;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predictor dut (
    .clk             (clk),
    .reset           (reset),
    .pc_f            (pc_f),
    .pred_taken_f    (pred_taken_f),
    .pred_target_f   (pred_target_f),
    .res_valid       (res_valid),
    .res_pc          (res_pc),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
`ifdef BRANCH_PRED_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counter as an integer 0..3, BTB as plain arrays.
  int          m_ctr    [NENT];
  bit          m_valid  [NENT];
  logic [31:0] m_tag    [NENT];
  logic [31:0] m_target [NENT];
  int          m_branches;
  int          m_mis;
  logic [31:0] last_rpc;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        t;
    logic [31:0] tgt;
    logic        pt;
    logic [31:0] ptgt;
    logic [31:0] probe;
    logic        e_rv;
    logic [31:0] e_rpc;
    logic        e_pt;
    logic [31:0] e_ptgt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % NENT);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / 32'd256;
  endfunction

  function automatic logic model_taken(input logic [31:0] pc);
    int i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] pc);
    int i = idx_of(pc);
    return m_valid[i] ? m_target[i] : 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_ctr[i] = 1; m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0;
    end
    m_branches = 0;
    m_mis      = 0;
    last_rpc   = '0;
    exp_q.delete();
  endtask

  task automatic model_resolve(input logic v, input logic [31:0] pc, input logic t,
                               input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    int i = idx_of(pc);
    if (!v) return;
    m_branches++;
    if ((t != pt) || (t && pt && (tgt != ptgt))) begin
      m_mis++;
      exp_q.push_back(t ? tgt : pc + 32'd4);
    end
    if (t) begin
      m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
      m_valid[i] = 1'b1; m_tag[i] = tag_of(pc); m_target[i] = tgt;
    end else begin
      m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
    end
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt, input logic [31:0] probe);
    res_valid = v; res_pc = pc; res_taken = t; res_target = tgt;
    res_pred_taken = pt; res_pred_target = ptgt; pc_f = probe;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, pc_f);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic add_vec(input logic v, input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt, input logic [31:0] probe,
                         input logic e_rv, input logic [31:0] e_rpc, input logic e_pt,
                         input logic [31:0] e_ptgt);
    vec_t x;
    x.v = v; x.pc = pc; x.t = t; x.tgt = tgt; x.pt = pt; x.ptgt = ptgt; x.probe = probe;
    x.e_rv = e_rv; x.e_rpc = e_rpc; x.e_pt = e_pt; x.e_ptgt = e_ptgt;
    vecs.push_back(x);
  endtask

  // Scoreboard step: one clock edge, then compare redirect outputs against the expected queue.
  task automatic edge_and_score(input string tag);
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      last_rpc = exp_q.pop_front();
      check({tag, "_redirect_valid"}, {31'h0, redirect_valid}, 32'h1);
    end else begin
      check({tag, "_redirect_valid"}, {31'h0, redirect_valid}, 32'h0);
    end
    check({tag, "_redirect_pc"}, redirect_pc, last_rpc);
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  initial begin
    reset = 1'b0;
    pc_f  = 32'h100;
    idle();

    //      v  res_pc        t  target        pt ptarget      probe         rv rpc           pt tgt
    add_vec(0, 32'h0,        0, 32'h0,        0, 32'h0,       32'h100,      0, 32'h0,        0, 32'h0);
    add_vec(1, 32'h100,      1, 32'h200,      0, 32'h0,       32'h100,      1, 32'h200,      1, 32'h200);
    add_vec(0, 32'h0,        0, 32'h0,        0, 32'h0,       32'h100,      0, 32'h200,      1, 32'h200);
    add_vec(1, 32'h100,      1, 32'h200,      1, 32'h200,     32'h100,      0, 32'h200,      1, 32'h200);
    add_vec(1, 32'h100,      0, 32'h0,        1, 32'h200,     32'h100,      1, 32'h104,      1, 32'h200);
    add_vec(1, 32'h100,      0, 32'h0,        1, 32'h200,     32'h100,      1, 32'h104,      0, 32'h200);
    add_vec(1, 32'h100,      1, 32'h200,      0, 32'h0,       32'h100,      1, 32'h200,      1, 32'h200);
    for (int k = 0; k < 4; k++)
      add_vec(1, 32'h100,    1, 32'h200,      1, 32'h200,     32'h100,      0, 32'h200,      1, 32'h200);
    add_vec(1, 32'h100,      0, 32'h0,        1, 32'h200,     32'h100,      1, 32'h104,      1, 32'h200);
    add_vec(1, 32'h200,      1, 32'h300,      0, 32'h0,       32'h100,      1, 32'h300,      0, 32'h300);
    add_vec(0, 32'h0,        0, 32'h0,        0, 32'h0,       32'h200,      0, 32'h300,      1, 32'h300);
    add_vec(1, 32'h200,      1, 32'h340,      1, 32'h300,     32'h200,      1, 32'h340,      1, 32'h340);
    add_vec(1, 32'hFFFF_FFFC,0, 32'h0,        1, 32'h0,       32'hFFFF_FFFC,1, 32'h0,        0, 32'h0);
    add_vec(0, 32'h100,      1, 32'h500,      0, 32'h0,       32'h300,      0, 32'h0,        0, 32'h340);
    add_vec(0, 32'h0,        0, 32'h0,        0, 32'h0,       32'h203,      0, 32'h0,        1, 32'h340);
    add_vec(1, 32'hFFFF_FFFC,1, 32'h10,       0, 32'h0,       32'hFFFF_FFFC,1, 32'h10,       0, 32'h10);

    // Reset state
    do_reset();
    check("reset_redirect_valid", {31'h0, redirect_valid}, 32'h0);
    check("reset_redirect_pc", redirect_pc, 32'h0);
    for (int k = 0; k < 4; k++) begin
      pc_f = 32'h100 + 32'(k) * 32'h44;
      #1;
      check("reset_pred_taken", {31'h0, pred_taken_f}, 32'h0);
      check("reset_pred_target", pred_target_f, 32'h0);
    end

    // Directed vector table
    foreach (vecs[n]) begin
      drive(vecs[n].v, vecs[n].pc, vecs[n].t, vecs[n].tgt, vecs[n].pt, vecs[n].ptgt, vecs[n].probe);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_redirect_valid", n), {31'h0, redirect_valid}, {31'h0, vecs[n].e_rv});
      check($sformatf("vec%0d_redirect_pc", n), redirect_pc, vecs[n].e_rpc);
      check($sformatf("vec%0d_pred_taken", n), {31'h0, pred_taken_f}, {31'h0, vecs[n].e_pt});
      check($sformatf("vec%0d_pred_target", n), pred_target_f, vecs[n].e_ptgt);
    end
    idle();
    @(posedge clk);
    #1;
    check("vec_end_redirect_drops", {31'h0, redirect_valid}, 32'h0);

    // Back-to-back mispredicts each produce their own one-cycle redirect
    do_reset();
    drive(1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 32'h0, 32'h400);
    model_resolve(1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check("b2b_first_valid", {31'h0, redirect_valid}, 32'h1);
    check("b2b_first_pc", redirect_pc, 32'h500);
    drive(1'b1, 32'h404, 1'b0, 32'h0, 1'b1, 32'h600, 32'h400);
    @(posedge clk);
    #1;
    check("b2b_second_valid", {31'h0, redirect_valid}, 32'h1);
    check("b2b_second_pc", redirect_pc, 32'h408);
    idle();
    @(posedge clk);
    #1;
    check("b2b_after_valid", {31'h0, redirect_valid}, 32'h0);
    check("b2b_after_pc", redirect_pc, 32'h408);
    check("b2b_trained_pred", {31'h0, pred_taken_f}, 32'h1);

    // Reset asserted during the redirect cycle clears everything immediately
    drive(1'b1, 32'h200, 1'b1, 32'h280, 1'b0, 32'h0, 32'h200);
    @(posedge clk);
    #1;
    check("rst_mid_valid_before", {31'h0, redirect_valid}, 32'h1);
    idle();
    #2 reset = 1'b1;
    #1;
    check("rst_mid_valid", {31'h0, redirect_valid}, 32'h0);
    check("rst_mid_pc", redirect_pc, 32'h0);
    check("rst_mid_pred_taken", {31'h0, pred_taken_f}, 32'h0);
    check("rst_mid_pred_target", pred_target_f, 32'h0);
`ifdef BRANCH_PRED_STATS_EN
    check("rst_mid_stat_branches", stat_branches, 32'h0);
    check("rst_mid_stat_mispredicts", stat_mispredicts, 32'h0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      logic        v, t, pt;
      logic [31:0] pc, tgt, ptgt, probe;
      v     = ($urandom_range(0, 3) != 0);
      pc    = rand_pc();
      t     = 1'($urandom_range(0, 1));
      tgt   = 32'($urandom_range(1, 6)) << 6;
      probe = ($urandom_range(0, 1) == 0) ? pc : rand_pc();
      if ($urandom_range(0, 3) != 0) begin
        pt   = model_taken(pc);
        ptgt = model_target(pc);
      end else begin
        pt   = 1'($urandom_range(0, 1));
        ptgt = 32'($urandom_range(1, 6)) << 6;
      end
      drive(v, pc, t, tgt, pt, ptgt, probe);
      #3;
      check("rand_pred_taken", {31'h0, pred_taken_f}, {31'h0, model_taken(probe)});
      check("rand_pred_target", pred_target_f, model_target(probe));
      model_resolve(v, pc, t, tgt, pt, ptgt);
      edge_and_score("rand");
    end
    idle();
    edge_and_score("rand_tail");
`ifdef BRANCH_PRED_STATS_EN
    check("stat_branches", stat_branches, 32'(m_branches));
    check("stat_mispredicts", stat_mispredicts, 32'(m_mis));
`endif

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
